trip_ctrl: RTL and testbench
============================

TRIP_CTRL -- requirements
Module: trip_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50_000_000, means clk_M cycles per 1 s tick.
REQ-002 Parameter RAMP_TICKS, default 1, means seconds per one-step speed change.
REQ-003 Parameter WAIT_LIMIT, default 180, means wait seconds at which overtime asserts.
REQ-004 Ports SHALL be (name  direction  width  meaning):
- clk_M  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start_req  in  1  one-cycle request to begin a trip.
- pause_req  in  1  one-cycle pause/resume toggle.
- wait_req  in  1  one-cycle red-light enter/leave toggle.
- end_req  in  1  one-cycle end-of-trip request.
- clr_req  in  1  one-cycle clear after DONE.
- speed_req  in  2  requested speed level 0..3.
- start  out  1  meter enable to distance/fee datapath.
- pause  out  1  meter pause.
- waitL  out  1  red-light wait indication.
- speedup  out  2  ramped speed level to distance and motor blocks.
- trip_state  out  3  current FSM state code.
- trip_done  out  1  one-cycle pulse on DONE entry.
- wait_sec  out  8  cumulative trip wait seconds.
- overtime  out  1  wait_sec >= WAIT_LIMIT.

Function
REQ-005 FSM states SHALL be IDLE=0, RUN=1, WAIT=2, PAUSE=3, DONE=4; codes 5..7 SHALL return to IDLE next cycle.
REQ-006 All outputs SHALL be registered; a request sampled at edge n takes effect on outputs after edge n.
REQ-007 Same-cycle requests SHALL be prioritized end_req > pause_req > wait_req > start_req; lower ones are dropped.
REQ-008 IDLE: start_req -> RUN; all others ignored.
REQ-009 RUN: end_req -> DONE; pause_req -> PAUSE (saved=RUN); wait_req -> WAIT.
REQ-010 WAIT: end_req -> DONE; pause_req -> PAUSE (saved=WAIT); wait_req -> RUN.
REQ-011 PAUSE: end_req -> DONE; pause_req -> saved state; wait_req and start_req ignored.
REQ-012 DONE: clr_req -> IDLE; all others ignored.
REQ-013 start SHALL be 1 in RUN, WAIT and PAUSE, and 0 in IDLE and DONE; pause SHALL be 1 only in PAUSE; waitL SHALL be 1 only in WAIT.
REQ-014 trip_done SHALL be high for exactly the first cycle in DONE.
REQ-015 A free-running prescaler SHALL emit a one-cycle tick every TICK_DIV cycles; only reset clears it.
REQ-016 speedup SHALL be 0 outside RUN. In RUN it SHALL move one step toward speed_req every RAMP_TICKS ticks, never overshooting. speed_req changes mid-ramp SHALL retarget without restarting the ramp interval.
REQ-017 wait_sec SHALL increment on each tick while in WAIT, saturating at 255.
REQ-018 wait_sec SHALL clear on the IDLE->RUN transition and hold its value in DONE.
REQ-019 overtime SHALL be combinationally equivalent to registered wait_sec >= WAIT_LIMIT, and SHALL be updated on the same edge as wait_sec.
REQ-020 A tick coinciding with a WAIT exit SHALL still be counted.

Reset
REQ-021 reset low SHALL immediately force: state IDLE, saved RUN, start=0, pause=0, waitL=0, speedup=0, trip_state=0, trip_done=0, wait_sec=0, overtime=0, prescaler and ramp counter 0.
REQ-022 Reset asserted mid-trip SHALL abandon the trip without a trip_done pulse.

Structure
REQ-023 A shared package SHALL hold the state codes and the speed-level width constant, for use by meter and motor blocks.
REQ-024 The prescaler SHALL be a sub-module tick_gen (parameter TICK_DIV, output tick); FSM, ramp and wait counter stay in trip_ctrl.

Verification (TICK_DIV=4, RAMP_TICKS=1, WAIT_LIMIT=3)
REQ-025 start_req, speed_req=3 -> start=1 next cycle; speedup steps 0->1->2->3, one step per tick, then holds at 3.
REQ-026 In RUN, wait_req, then hold 3 ticks -> waitL=1, speedup=0, wait_sec=3, overtime=1; a second wait_req -> RUN, and the ramp restarts from 0.
REQ-027 In WAIT, pause_req, pause_req -> PAUSE, then back to WAIT; wait_sec does not advance while in PAUSE.
REQ-028 pause_req+wait_req+end_req in one cycle from RUN -> DONE, trip_done pulse of 1 cycle, start=0; start_req ignored; clr_req -> IDLE; next start_req clears wait_sec to 0.
REQ-029 reset low during WAIT with wait_sec=2 -> all outputs 0 asynchronously, no trip_done pulse; force trip_state=6 internally -> IDLE next cycle.

Source files
------------

// File: rtl/trip_ctrl_pkg.sv
// trip_ctrl_pkg: trip state codes and speed-level width shared with the meter and motor blocks
package trip_ctrl_pkg;
    localparam int SPEED_W = 2;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        WAIT  = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } trip_state_e;
endpackage

// File: rtl/trip_ctrl_tick_gen.sv
// tick_gen: free-running prescaler emitting a one-cycle tick every TICK_DIV cycles
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk_M,
    input  logic reset,
    output logic tick
);
    localparam int CW = $clog2(TICK_DIV + 1);
    logic [CW-1:0] cnt;
    assign tick = cnt == CW'(TICK_DIV - 1);
    always_ff @(posedge clk_M or negedge reset) begin
        if (!reset) cnt <= '0;
        else cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/trip_ctrl.sv
// trip_ctrl: taxi trip FSM with ramped speed output and red-light wait-seconds counter
module trip_ctrl
    import trip_ctrl_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int RAMP_TICKS = 1,
    parameter int WAIT_LIMIT = 180
) (
    input  logic               clk_M,
    input  logic               reset,
    input  logic               start_req,
    input  logic               pause_req,
    input  logic               wait_req,
    input  logic               end_req,
    input  logic               clr_req,
    input  logic [SPEED_W-1:0] speed_req,
    output logic               start,
    output logic               pause,
    output logic               waitL,
    output logic [SPEED_W-1:0] speedup,
    output logic [2:0]         trip_state,
    output logic               trip_done,
    output logic [7:0]         wait_sec,
    output logic               overtime
);
    localparam int RW = $clog2(RAMP_TICKS + 1);
    trip_state_e state, nxt, saved;
    logic tick, ramp_done;
    logic start_d, pause_d, waitl_d, done_d;
    logic [RW-1:0] ramp_cnt;
    logic [SPEED_W-1:0] step, speed_d;
    logic [7:0] wsec_d;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk_M (clk_M),
        .reset (reset),
        .tick  (tick)
    );

    assign trip_state = state;
    assign ramp_done  = ramp_cnt == RW'(RAMP_TICKS - 1);

    always_ff @(posedge clk_M or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            saved     <= RUN;
            start     <= 1'b0;
            pause     <= 1'b0;
            waitL     <= 1'b0;
            trip_done <= 1'b0;
            speedup   <= '0;
            ramp_cnt  <= '0;
            wait_sec  <= '0;
            overtime  <= 1'b0;
        end else begin
            state     <= nxt;
            if (nxt == PAUSE && state != PAUSE) saved <= state;
            start     <= start_d;
            pause     <= pause_d;
            waitL     <= waitl_d;
            trip_done <= done_d;
            speedup   <= speed_d;
            ramp_cnt  <= state != RUN ? '0 : tick ? (ramp_done ? '0 : ramp_cnt + 1'b1) : ramp_cnt;
            wait_sec  <= wsec_d;
            overtime  <= 32'(wsec_d) >= WAIT_LIMIT;
        end
    end

    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE:      nxt = start_req ? RUN : IDLE;
            RUN, WAIT: nxt = end_req ? DONE : pause_req ? PAUSE :
                             wait_req ? (state == RUN ? WAIT : RUN) : state;
            PAUSE:     nxt = end_req ? DONE : pause_req ? saved : PAUSE;
            DONE:      nxt = clr_req ? IDLE : DONE;
            default:   nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered on the same edge
    always_comb begin
        start_d = nxt inside {RUN, WAIT, PAUSE};
        pause_d = nxt == PAUSE;
        waitl_d = nxt == WAIT;
        done_d  = nxt == DONE && state != DONE;
        step    = speed_req > speedup ? speedup + 1'b1 :
                  speed_req < speedup ? speedup - 1'b1 : speedup;
        speed_d = nxt != RUN ? '0 : (state == RUN && tick && ramp_done) ? step : speedup;
        wsec_d  = (state == IDLE && nxt == RUN) ? '0 :
                  (state == WAIT && tick && wait_sec != 8'hFF) ? wait_sec + 8'd1 : wait_sec;
    end
endmodule

// File: tb/tb_trip_ctrl.sv
// tb_trip_ctrl: directed and random checks of trip_ctrl against a behavioural trip model
module tb_trip_ctrl;
    import trip_ctrl_pkg::*;
    localparam int TD = 4, RT = 1, WL = 3;
    localparam logic [4:0] S = 5'd1, P = 5'd2, W = 5'd4, E = 5'd8, C = 5'd16;

    logic clk_M = 1'b0, reset = 1'b0;
    logic start_req = 1'b0, pause_req = 1'b0, wait_req = 1'b0, end_req = 1'b0, clr_req = 1'b0;
    logic [1:0] speed_req = 2'd0;
    logic start, pause, waitL, trip_done, overtime;
    logic [1:0] speedup;
    logic [2:0] trip_state;
    logic [7:0] wait_sec;

    int total = 0, bad = 0;
    int m_state, m_saved, m_speed, m_ramp, m_wsec, m_presc, m_done;

    always #5 clk_M = ~clk_M;

    trip_ctrl #(.TICK_DIV(TD), .RAMP_TICKS(RT), .WAIT_LIMIT(WL)) dut (
        .clk_M      (clk_M),
        .reset      (reset),
        .start_req  (start_req),
        .pause_req  (pause_req),
        .wait_req   (wait_req),
        .end_req    (end_req),
        .clr_req    (clr_req),
        .speed_req  (speed_req),
        .start      (start),
        .pause      (pause),
        .waitL      (waitL),
        .speedup    (speedup),
        .trip_state (trip_state),
        .trip_done  (trip_done),
        .wait_sec   (wait_sec),
        .overtime   (overtime)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_saved = 1; m_speed = 0; m_ramp = 0; m_wsec = 0; m_presc = 0; m_done = 0;
    endtask

    // Trip behaviour at one rising edge: r = {clr,end,wait,pause,start}
    task automatic model_edge(input logic [4:0] r, input int sp);
        int nxt;
        bit tick;
        tick = m_presc == TD - 1;
        m_presc = (m_presc + 1) % TD;
        nxt = m_state;
        case (m_state)
            0: if (r[0]) nxt = 1;
            1, 2: if (r[3]) nxt = 4;
                  else if (r[1]) begin m_saved = m_state; nxt = 3; end
                  else if (r[2]) nxt = (m_state == 1) ? 2 : 1;
            3: if (r[3]) nxt = 4; else if (r[1]) nxt = m_saved;
            4: if (r[4]) nxt = 0;
            default: nxt = 0;
        endcase
        if (m_state == 2 && tick && m_wsec < 255) m_wsec++;
        if (m_state == 0 && nxt == 1) m_wsec = 0;
        if (m_state == 1 && tick) begin
            m_ramp++;
            if (m_ramp == RT) begin
                m_ramp = 0;
                if (m_speed < sp) m_speed++;
                else if (m_speed > sp) m_speed--;
            end
        end
        if (m_state != 1) m_ramp = 0;
        if (nxt != 1) m_speed = 0;
        m_done = (nxt == 4 && m_state != 4) ? 1 : 0;
        m_state = nxt;
    endtask

    task automatic check_all();
        chk("start", 32'(start), 32'(m_state inside {1, 2, 3}));
        chk("pause", 32'(pause), 32'(m_state == 3));
        chk("waitL", 32'(waitL), 32'(m_state == 2));
        chk("speedup", 32'(speedup), 32'(m_speed));
        chk("trip_state", 32'(trip_state), 32'(m_state));
        chk("trip_done", 32'(trip_done), 32'(m_done));
        chk("wait_sec", 32'(wait_sec), 32'(m_wsec));
        chk("overtime", 32'(overtime), 32'(m_wsec >= WL));
    endtask

    task automatic step(input logic [4:0] r);
        @(negedge clk_M);
        {clr_req, end_req, wait_req, pause_req, start_req} = r;
        @(posedge clk_M);
        model_edge(r, int'(speed_req));
        #1;
        {clr_req, end_req, wait_req, pause_req, start_req} = '0;
        check_all();
    endtask

    task automatic zeros_now(input string tag);
        chk({tag, "_start"}, 32'(start), 0);
        chk({tag, "_pause"}, 32'(pause), 0);
        chk({tag, "_waitL"}, 32'(waitL), 0);
        chk({tag, "_speedup"}, 32'(speedup), 0);
        chk({tag, "_state"}, 32'(trip_state), 0);
        chk({tag, "_done"}, 32'(trip_done), 0);
        chk({tag, "_wsec"}, 32'(wait_sec), 0);
        chk({tag, "_overtime"}, 32'(overtime), 0);
    endtask

    task automatic count_ramp(input string tag, input int n);
        int ups;
        logic [1:0] prev;
        ups = 0;
        for (int i = 0; i < n; i++) begin
            prev = speedup;
            step(5'd0);
            if (int'(speedup) == int'(prev) + 1) ups++;
        end
        chk(tag, 32'(ups), 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ws;
        logic [4:0] r;
        model_reset();
        repeat (2) @(posedge clk_M);
        #1 zeros_now("reset");
        reset = 1'b1;

        speed_req = 2'd3;
        step(S);
        chk("r025_start", 32'(start), 1);
        count_ramp("r025_ups", 16);
        chk("r025_hold", 32'(speedup), 3);

        step(W);
        chk("r026_waitL", 32'(waitL), 1);
        chk("r026_speed0", 32'(speedup), 0);
        repeat (12) step(5'd0);
        chk("r026_wsec3", 32'(wait_sec), 3);
        chk("r026_overtime", 32'(overtime), 1);
        step(W);
        chk("r026_run", 32'(trip_state), 1);
        chk("r026_restart", 32'(speedup), 0);
        count_ramp("r026_ups", 16);

        step(W);
        step(P);
        chk("r027_pstate", 32'(trip_state), 3);
        chk("r027_pause", 32'(pause), 1);
        ws = wait_sec;
        repeat (12) step(5'd0);
        chk("r027_frozen", 32'(wait_sec), 32'(ws));
        step(P);
        chk("r027_back", 32'(trip_state), 2);
        chk("r027_waitL", 32'(waitL), 1);

        step(W);
        step(P | W | E);
        chk("r028_done_state", 32'(trip_state), 4);
        chk("r028_pulse", 32'(trip_done), 1);
        chk("r028_start0", 32'(start), 0);
        step(S);
        chk("r028_pulse_end", 32'(trip_done), 0);
        chk("r028_ignore", 32'(trip_state), 4);
        step(C);
        chk("r028_idle", 32'(trip_state), 0);
        step(S);
        chk("r028_wclr", 32'(wait_sec), 0);
        chk("r028_run", 32'(trip_state), 1);

        step(W);
        for (int i = 0; i < 20 && wait_sec != 8'd2; i++) step(5'd0);
        chk("r029_wsec2", 32'(wait_sec), 2);
        #2 reset = 1'b0;
        #1 zeros_now("r029_async");
        model_reset();
        @(posedge clk_M);
        #1 chk("r029_nodone", 32'(trip_done), 0);
        reset = 1'b1;
        step(5'd0);
        force dut.state = trip_state_e'(3'd6);
        #1 release dut.state;
        chk("r029_forced", 32'(trip_state), 6);
        m_state = 6;
        step(5'd0);
        chk("r029_recover", 32'(trip_state), 0);

        for (int i = 0; i < 600; i++) begin
            r = '0;
            for (int b = 0; b < 5; b++) if ($urandom_range(7) == 0) r[b] = 1'b1;
            if ($urandom_range(5) == 0) speed_req = 2'($urandom_range(3));
            step(r);
        end

        @(posedge clk_M);
        #2 reset = 1'b0;
        model_reset();
        @(posedge clk_M);
        #1 reset = 1'b1;
        step(S);
        step(W);
        repeat (1030) step(5'd0);
        chk("sat_255", 32'(wait_sec), 255);
        repeat (8) step(5'd0);
        chk("sat_hold", 32'(wait_sec), 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
